sevenseg_scanner: RTL

SEVENSEG_SCANNER -- requirements
Module: sevenseg_scanner

---
 rtl/sevenseg_scanner_if.sv | 30 +++
 rtl/sevenseg_scanner.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sevenseg_scanner_if.sv
// Bundles the load-side inputs and display-side outputs of the seven-segment scanner.
//   value_i : four hex nibbles, nibble k -> digit k (digit 0 rightmost)
//   dp_i    : decimal-point request per digit, active-high
//   en_i    : digit enable per digit, active-high
//   load_i  : one-cycle strobe capturing value_i/dp_i/en_i into the shadow register
//   seg     : segments g..a (seg[0]=a), active-low
//   an      : digit anodes, active-low, at most one low
//   dp      : decimal point, active-low
//   frame_o : one-cycle pulse at each frame boundary
// master drives the load side; slave is the scanner.
interface sevenseg_scanner_if;
  logic [15:0] value_i;
  logic [3:0]  dp_i;
  logic [3:0]  en_i;
  logic        load_i;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        dp;
  logic        frame_o;

  modport master (
    output value_i, dp_i, en_i, load_i,
    input  seg, an, dp, frame_o
  );

  modport slave (
    input  value_i, dp_i, en_i, load_i,
    output seg, an, dp, frame_o
  );
endinterface

// File: rtl/sevenseg_scanner.sv
// Four-digit multiplexed seven-segment scanner.
//   clk  : core clock, all logic on the rising edge
//   rst  : synchronous, active-high reset
//   bus  : sevenseg_scanner_if.slave (load inputs in, registered display outputs out)
// Each digit owns DIGIT_CYCLES clocks; the first BLANK_CYCLES of every slot keep all anodes
// off to avoid ghosting. New values land in a shadow register and only move to the display
// register at the frame boundary, so a frame never mixes old and new values.
module sevenseg_scanner #(
  parameter int unsigned DIGIT_CYCLES = 2500,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input logic              clk,
  input logic              rst,
  sevenseg_scanner_if.slave bus
);

  localparam int unsigned CntW = $clog2(DIGIT_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DIGIT_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;

  logic [15:0] sh_val_q, sh_val_d;
  logic [3:0]  sh_dp_q, sh_dp_d;
  logic [3:0]  sh_en_q, sh_en_d;
  logic [15:0] ds_val_q, ds_val_d;
  logic [3:0]  ds_dp_q, ds_dp_d;
  logic [3:0]  ds_en_q, ds_en_d;

  logic [6:0] seg_q, seg_d;
  logic [3:0] an_q, an_d;
  logic       dp_q, dp_d;
  logic       frame_q, frame_d;

  logic       boundary;
  logic       slot_wrap;
  logic       lit;
  logic [3:0] nibble;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  always_comb begin
    slot_wrap = (cnt_q == CntMax);
    boundary  = slot_wrap && (idx_q == 2'd3);

    cnt_d = slot_wrap ? '0 : cnt_q + 1'b1;
    idx_d = slot_wrap ? idx_q + 2'd1 : idx_q;

    sh_val_d = sh_val_q;
    sh_dp_d  = sh_dp_q;
    sh_en_d  = sh_en_q;
    if (bus.load_i) begin
      sh_val_d = bus.value_i;
      sh_dp_d  = bus.dp_i;
      sh_en_d  = bus.en_i;
    end

    // A load landing on the boundary goes straight to the display; otherwise the
    // frame that is about to start would still show the previous shadow contents.
    ds_val_d = ds_val_q;
    ds_dp_d  = ds_dp_q;
    ds_en_d  = ds_en_q;
    if (boundary) begin
      ds_val_d = sh_val_d;
      ds_dp_d  = sh_dp_d;
      ds_en_d  = sh_en_d;
    end

    // Outputs are computed from the current scan state and registered below.
    nibble  = ds_val_q[{idx_q, 2'b00} +: 4];
    lit     = (32'(cnt_q) >= BLANK_CYCLES) && ds_en_q[idx_q];
    seg_d   = 7'b1111111;
    an_d    = 4'b1111;
    dp_d    = 1'b1;
    frame_d = boundary;
    if (lit) begin
      seg_d        = hex_to_seg(nibble);
      an_d[idx_q]  = 1'b0;
      dp_d         = ~ds_dp_q[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_val_q <= '0;
      sh_dp_q  <= '0;
      sh_en_q  <= '0;
      ds_val_q <= '0;
      ds_dp_q  <= '0;
      ds_en_q  <= '0;
      seg_q    <= 7'b1111111;
      an_q     <= 4'b1111;
      dp_q     <= 1'b1;
      frame_q  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_val_q <= sh_val_d;
      sh_dp_q  <= sh_dp_d;
      sh_en_q  <= sh_en_d;
      ds_val_q <= ds_val_d;
      ds_dp_q  <= ds_dp_d;
      ds_en_q  <= ds_en_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      dp_q     <= dp_d;
      frame_q  <= frame_d;
    end
  end

  assign bus.seg     = seg_q;
  assign bus.an      = an_q;
  assign bus.dp      = dp_q;
  assign bus.frame_o = frame_q;

endmodule
